yutorina_id_stage: RTL

YUTORINA_ID_STAGE -- requirements
Module: yutorina_id_stage

---
 rtl/yutorina_id_stage_pkg.sv | 37 +++
 rtl/yutorina_id_forward.sv | 32 +++
 rtl/yutorina_id_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/yutorina_id_stage_pkg.sv
// Shared ISA header for the Yutorina decode stage: field positions, widths,
// special opcode values and the raw instruction decoder.
package yutorina_id_stage_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned CLASS_W = 3;
    localparam int unsigned IMM_W   = 16;

    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RA_LSB  = 21;
    localparam int unsigned RB_LSB  = 16;
    localparam int unsigned RC_LSB  = 11;

    localparam logic [OPC_W-1:0]   ISA_LOAD_OPCODE = 6'h22;
    localparam logic [CLASS_W-1:0] ISA_STORE_CLASS = 3'b111;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic [REG_AW-1:0] rc;
        logic [WORD_W-1:0] imm;
    } decoded_t;

    function automatic decoded_t decode(input logic [WORD_W-1:0] insn);
        decoded_t d;
        d.opcode = insn[OPC_LSB +: OPC_W];
        d.ra     = insn[RA_LSB +: REG_AW];
        d.rb     = insn[RB_LSB +: REG_AW];
        d.rc     = insn[RC_LSB +: REG_AW];
        d.imm    = {{(WORD_W-IMM_W){insn[IMM_W-1]}}, insn[IMM_W-1:0]};
        return d;
    endfunction

endpackage

// File: rtl/yutorina_id_forward.sv
// Source-operand bypass mux: EX result beats MEM result beats register file;
// register 0 always reads as zero.
module yutorina_id_forward
    import yutorina_id_stage_pkg::*;
(
    input  logic [REG_AW-1:0] i_src_addr,
    input  logic [WORD_W-1:0] i_gpr_data,
    input  logic [REG_AW-1:0] i_ex_dst_addr,
    input  logic              i_ex_we_n,
    input  logic [WORD_W-1:0] i_ex_result,
    input  logic [REG_AW-1:0] i_mem_dst_addr,
    input  logic              i_mem_we_n,
    input  logic [WORD_W-1:0] i_mem_result,
    output logic [WORD_W-1:0] o_value
);

    logic w_src_zero;
    logic w_ex_hit;
    logic w_mem_hit;

    assign w_src_zero = (i_src_addr == '0);
    assign w_ex_hit   = !i_ex_we_n  && (i_ex_dst_addr  == i_src_addr);
    assign w_mem_hit  = !i_mem_we_n && (i_mem_dst_addr == i_src_addr);

    always_comb begin
        o_value = i_gpr_data;
        if (w_src_zero)     o_value = '0;
        else if (w_ex_hit)  o_value = i_ex_result;
        else if (w_mem_hit) o_value = i_mem_result;
    end

endmodule

// File: rtl/yutorina_id_stage.sv
// Instruction decode stage: field decode, operand bypass, load-use hazard
// detection and the ID/EX pipeline register with stall/flush control.
module yutorina_id_stage
    import yutorina_id_stage_pkg::*;
#(
    parameter logic [OPC_W-1:0]   LOAD_OPCODE = ISA_LOAD_OPCODE,
    parameter logic [CLASS_W-1:0] STORE_CLASS = ISA_STORE_CLASS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [WORD_W-1:0] if_pc,
    input  logic [WORD_W-1:0] if_insn,
    output logic [REG_AW-1:0] gpr_read_address0,
    output logic [REG_AW-1:0] gpr_read_address1,
    input  logic [WORD_W-1:0] gpr_read_data0,
    input  logic [WORD_W-1:0] gpr_read_data1,
    input  logic [REG_AW-1:0] ex_dst_address,
    input  logic              ex_write_enable_,
    input  logic              ex_is_load,
    input  logic [WORD_W-1:0] ex_result,
    input  logic [REG_AW-1:0] mem_dst_address,
    input  logic              mem_write_enable_,
    input  logic [WORD_W-1:0] mem_result,
    input  logic              stall,
    input  logic              flush,
    output logic              id_stall,
    output logic              id_valid,
    output logic [WORD_W-1:0] id_pc,
    output logic [OPC_W-1:0]  id_opcode,
    output logic [WORD_W-1:0] id_operand_a,
    output logic [WORD_W-1:0] id_operand_b,
    output logic [WORD_W-1:0] id_store_data,
    output logic [REG_AW-1:0] id_dst_address,
    output logic              id_write_enable_,
    output logic              id_is_load
);

    decoded_t          w_dec;
    logic              w_is_imm;
    logic              w_store_class;
    logic              w_rb_used;
    logic [WORD_W-1:0] w_val_a;
    logic [WORD_W-1:0] w_val_b;
    logic [REG_AW-1:0] w_dst;
    logic              w_we_n;
    logic              w_is_load;
    logic              w_ex_load_pending;

    logic              r_valid;
    logic [WORD_W-1:0] r_pc;
    logic [OPC_W-1:0]  r_opcode;
    logic [WORD_W-1:0] r_operand_a;
    logic [WORD_W-1:0] r_operand_b;
    logic [WORD_W-1:0] r_store_data;
    logic [REG_AW-1:0] r_dst;
    logic              r_we_n;
    logic              r_is_load;

    assign w_dec         = decode(if_insn);
    assign w_is_imm      = w_dec.opcode[OPC_W-1];
    assign w_store_class = (w_dec.opcode[OPC_W-1 -: CLASS_W] == STORE_CLASS);
    assign w_rb_used     = !w_is_imm || w_store_class;

    assign gpr_read_address0 = w_dec.ra;
    assign gpr_read_address1 = w_dec.rb;

    yutorina_id_forward u_fwd_a (
        .i_src_addr    (w_dec.ra),
        .i_gpr_data    (gpr_read_data0),
        .i_ex_dst_addr (ex_dst_address),
        .i_ex_we_n     (ex_write_enable_),
        .i_ex_result   (ex_result),
        .i_mem_dst_addr(mem_dst_address),
        .i_mem_we_n    (mem_write_enable_),
        .i_mem_result  (mem_result),
        .o_value       (w_val_a)
    );

    yutorina_id_forward u_fwd_b (
        .i_src_addr    (w_dec.rb),
        .i_gpr_data    (gpr_read_data1),
        .i_ex_dst_addr (ex_dst_address),
        .i_ex_we_n     (ex_write_enable_),
        .i_ex_result   (ex_result),
        .i_mem_dst_addr(mem_dst_address),
        .i_mem_we_n    (mem_write_enable_),
        .i_mem_result  (mem_result),
        .o_value       (w_val_b)
    );

    assign w_dst     = w_is_imm ? w_dec.rb : w_dec.rc;
    assign w_we_n    = !(if_valid && (w_dst != '0) && !w_store_class);
    assign w_is_load = if_valid && (w_dec.opcode == LOAD_OPCODE);

    // A load in EX has no result yet, so any consumer must wait one cycle.
    assign w_ex_load_pending = if_valid && ex_is_load && !ex_write_enable_ && (ex_dst_address != '0);
    assign id_stall = w_ex_load_pending &&
                      ((ex_dst_address == w_dec.ra) || (w_rb_used && (ex_dst_address == w_dec.rb)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_opcode     <= '0;
            r_operand_a  <= '0;
            r_operand_b  <= '0;
            r_store_data <= '0;
            r_dst        <= '0;
            r_we_n       <= 1'b1;
            r_is_load    <= 1'b0;
        end else if (flush || (!stall && id_stall)) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_opcode     <= '0;
            r_operand_a  <= '0;
            r_operand_b  <= '0;
            r_store_data <= '0;
            r_dst        <= '0;
            r_we_n       <= 1'b1;
            r_is_load    <= 1'b0;
        end else if (!stall) begin
            r_valid      <= if_valid;
            r_pc         <= if_pc;
            r_opcode     <= w_dec.opcode;
            r_operand_a  <= w_val_a;
            r_operand_b  <= w_is_imm ? w_dec.imm : w_val_b;
            r_store_data <= w_val_b;
            r_dst        <= w_dst;
            r_we_n       <= w_we_n;
            r_is_load    <= w_is_load;
        end
    end

    assign id_valid         = r_valid;
    assign id_pc            = r_pc;
    assign id_opcode        = r_opcode;
    assign id_operand_a     = r_operand_a;
    assign id_operand_b     = r_operand_b;
    assign id_store_data    = r_store_data;
    assign id_dst_address   = r_dst;
    assign id_write_enable_ = r_we_n;
    assign id_is_load       = r_is_load;

endmodule
